seg7_bcd_counter_mux: RTL and testbench

Parametrised N-digit BCD up/down counter with a time-multiplexed seven-segment driver, the multi-digit successor to the single-digit seconds display. A prescaler derives a count tick from `clk`. The counter value drives one digit at a time, using one-hot digit select and a shared segment bus. It sits directly behind the chip I/O wrapper, and its outputs map onto the `io_out` pins.

---
 rtl/seg7_bcd_counter_mux.sv | 184 ++++++++++++++++++
 tb/tb_seg7_bcd_counter_mux.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_counter_mux.sv
// N-digit BCD up/down counter with a prescaled count tick and a time-multiplexed seven-segment driver.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_bcd_counter_mux #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10_000_000,
  parameter int MUX_DIV  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MCNT_LAST  = MW'(MUX_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [4*DIGITS-1:0]   r_count;
  logic                  r_wrap_pend;
  logic                  r_wrap;
  logic [MW-1:0]         r_mcnt;
  logic [IW-1:0]         r_idx;
  logic [6:0]            r_segments;
  logic [DIGITS-1:0]     r_digit_sel;

  logic                  w_tick;
  logic [4*DIGITS-1:0]   w_count_nxt;
  logic                  w_wrap_cond;
  logic [3:0]            w_cur_digit;
  logic                  w_cur_blank;
  logic [6:0]            w_seg_nxt;
  logic [DIGITS-1:0]     w_sel_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // clr wins over everything, so a colliding tick never reaches the counter or wrap.
  assign w_tick = en & ~clr & (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (clr) begin
      r_presc <= '0;
    end else if (en) begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Ripple increment/decrement; a carry/borrow out of the top digit is the wrap condition.
  always_comb begin
    logic [3:0] nib;
    logic       carry;
    nib         = 4'd0;
    carry       = 1'b1;
    w_count_nxt = r_count;
    for (int k = 0; k < DIGITS; k++) begin
      nib = r_count[4*k +: 4];
      if (carry) begin
        if (up) begin
          if (nib >= 4'd9) begin
            nib = 4'd0;
          end else begin
            nib   = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0 || nib > 4'd9) begin
            nib = 4'd9;
          end else begin
            nib   = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
      w_count_nxt[4*k +: 4] = nib;
    end
    w_wrap_cond = carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_wrap_pend <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      if (clr) begin
        r_count <= '0;
      end else if (w_tick) begin
        r_count <= w_count_nxt;
      end
      // wrap is reported one cycle after the count edge that wrapped.
      r_wrap_pend <= w_tick & w_wrap_cond;
      r_wrap      <= r_wrap_pend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcnt <= '0;
      r_idx  <= '0;
    end else if (r_mcnt == MCNT_LAST) begin
      r_mcnt <= '0;
      if (r_idx == IDX_LAST) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end else begin
      r_mcnt <= r_mcnt + MW'(1);
    end
  end

  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    w_cur_digit = 4'd0;
    w_cur_blank = 1'b0;
    w_sel_nxt   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero & (r_count[4*k +: 4] == 4'd0);
      if (IW'(k) == r_idx) begin
        w_cur_digit  = r_count[4*k +: 4];
        w_sel_nxt[k] = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        w_cur_blank  = (k != 0) && higher_zero;
`endif
      end
    end
  end

  always_comb begin
    w_seg_nxt = f_decode(w_cur_digit);
    if (w_cur_blank) begin
      w_seg_nxt = 7'h00;
    end
  end

  // Select and segment pattern are registered together so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_segments  <= 7'h00;
      r_digit_sel <= '0;
    end else begin
      r_segments  <= w_seg_nxt;
      r_digit_sel <= w_sel_nxt;
    end
  end

  assign segments  = r_segments;
  assign digit_sel = r_digit_sel;
  assign count_bcd = r_count;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_seg7_bcd_counter_mux.sv
// Bench for seg7_bcd_counter_mux: decimal-arithmetic model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_seg7_bcd_counter_mux;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int MUX_DIV  = 2;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_ZERO_SEG = 7'h00;
`else
  localparam logic [6:0] LEAD_ZERO_SEG = 7'h3F;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                up = 1'b1;
  logic                clr = 1'b0;
  logic [6:0]          segments;
  logic [DIGITS-1:0]   digit_sel;
  logic [4*DIGITS-1:0] count_bcd;
  logic                wrap;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seg7_bcd_counter_mux #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .MUX_DIV  (MUX_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .clr       (clr),
    .segments  (segments),
    .digit_sel (digit_sel),
    .count_bcd (count_bcd),
    .wrap      (wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  int                m_mod = pow10(DIGITS);
  int                m_val = 0;
  int                m_presc = 0;
  int                m_mcnt = 0;
  int                m_idx = 0;
  int                m_dg = 0;
  bit                m_tk = 1'b0;
  logic              m_wrap_pend = 1'b0;
  logic              m_wrap = 1'b0;
  logic [6:0]        m_seg = 7'h00;
  logic [DIGITS-1:0] m_sel = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_val = 0; m_presc = 0; m_mcnt = 0; m_idx = 0;
      m_wrap_pend = 1'b0; m_wrap = 1'b0; m_seg = 7'h00; m_sel = '0;
    end else begin
      m_tk  = en && !clr && (m_presc == TICK_DIV - 1);
      m_dg  = (m_val / pow10(m_idx)) % 10;
      m_sel = DIGITS'(1) << m_idx;
      m_seg = seg_tab[m_dg];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && (m_val / pow10(m_idx)) == 0) m_seg = 7'h00;
`endif
      m_wrap      = m_wrap_pend;
      m_wrap_pend = m_tk && (up ? (m_val == m_mod - 1) : (m_val == 0));
      if (clr) m_val = 0;
      else if (m_tk) m_val = up ? (m_val + 1) % m_mod : (m_val + m_mod - 1) % m_mod;
      if (clr) m_presc = 0;
      else if (en) m_presc = (m_presc + 1) % TICK_DIV;
      m_mcnt = (m_mcnt + 1) % MUX_DIV;
      if (m_mcnt == 0) m_idx = (m_idx + 1) % DIGITS;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    #1;
    check("count_bcd", 32'(count_bcd), 32'(to_bcd(m_val)));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("digit_sel", 32'(digit_sel), 32'(m_sel));
    check("segments", 32'(segments), 32'(m_seg));
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit         seen01, seen10, found;
    logic [6:0] seg_d0, seg_d1;
    int         budget;

    repeat (4) @(negedge clk);
    check("rst_segments", 32'(segments), 32'h00);
    check("rst_digit_sel", 32'(digit_sel), 32'h0);
    check("rst_count", 32'(count_bcd), 32'h00);
    check("rst_wrap", 32'(wrap), 32'h0);

    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    @(posedge clk); #1;
    check("first_digit_sel", 32'(digit_sel), 32'h1);
    check("first_segments", 32'(segments), 32'h3F);

    repeat (19) @(posedge clk); #1;
    check("count_05", 32'(count_bcd), 32'h05);
    seg_d0 = 7'h55; seg_d1 = 7'h55;
    repeat (4) begin
      @(posedge clk); #1;
      if (digit_sel == 2'b01) seg_d0 = segments;
      if (digit_sel == 2'b10) seg_d1 = segments;
    end
    check("digit0_seg_5", 32'(seg_d0), 32'h6D);
    check("digit1_lead_zero", 32'(seg_d1), 32'(LEAD_ZERO_SEG));

    repeat (16) @(posedge clk); #1;
    check("count_10", 32'(count_bcd), 32'h10);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(posedge clk); #1;
      if (digit_sel == 2'b10) begin
        found = 1'b1;
        check("carry_digit1_seg", 32'(segments), 32'h06);
      end
    end
    check("carry_digit1_seen", 32'(found), 32'h1);

    budget = 1000;
    while (m_val != 99 && budget > 0) begin @(posedge clk); #1; budget--; end
    check("reach_99", 32'(count_bcd), 32'h99);
    budget = 20;
    while (m_val == 99 && budget > 0) begin @(posedge clk); #1; budget--; end
    check("up_wrap_count", 32'(count_bcd), 32'h00);
    check("up_wrap_not_yet", 32'(wrap), 32'h0);
    @(posedge clk); #1;
    check("up_wrap_pulse", 32'(wrap), 32'h1);
    @(posedge clk); #1;
    check("up_wrap_single", 32'(wrap), 32'h0);

    @(negedge clk); up = 1'b0;
    budget = 20;
    while (m_val == 0 && budget > 0) begin @(posedge clk); #1; budget--; end
    check("down_wrap_count", 32'(count_bcd), 32'h99);
    @(posedge clk); #1;
    check("down_wrap_pulse", 32'(wrap), 32'h1);

    @(negedge clk); en = 1'b0;
    seen01 = 1'b0; seen10 = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (digit_sel == 2'b01) seen01 = 1'b1;
      if (digit_sel == 2'b10) seen10 = 1'b1;
    end
    check("hold_99", 32'(count_bcd), 32'h99);
    check("hold_mux_scans", 32'({seen10, seen01}), 32'h3);

    @(negedge clk); up = 1'b1; en = 1'b1;
    budget = 20;
    while (m_presc != TICK_DIV - 1 && budget > 0) begin @(negedge clk); budget--; end
    check("clr_align", 32'(budget > 0), 32'h1);
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr_count", 32'(count_bcd), 32'h00);
    @(negedge clk); clr = 1'b0;
    @(posedge clk); #1;
    check("clr_no_wrap", 32'(wrap), 32'h0);
    repeat (2) @(posedge clk); #1;
    check("clr_no_early_tick", 32'(count_bcd), 32'h00);
    @(posedge clk); #1;
    check("clr_tick_after_4", 32'(count_bcd), 32'h01);

    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_count", 32'(count_bcd), 32'h00);
    check("midrst_segments", 32'(segments), 32'h00);
    check("midrst_digit_sel", 32'(digit_sel), 32'h0);
    check("midrst_wrap", 32'(wrap), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rerel_digit_sel", 32'(digit_sel), 32'h1);
    check("rerel_segments", 32'(segments), 32'h3F);
    repeat (6) @(posedge clk);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
